curl_hash_driver: RTL and testbench

- Transaction front-end (initiator) for the multicycle Curl transform unit.
- Accepts one 243-trit block (486 bits, 2 bits per trit) on a valid/ready input port and loads it into the transform unit as two 243-bit halves: low half with the first-part strobe, high half with the new-hash strobe.
- Waits for the transform-finish flag, captures the 486-bit result, and returns it on a valid/ready output port.
- Rejects blocks containing illegal trit codes without starting a transform.

---
 rtl/curl_pkg.sv | 26 ++
 rtl/curl_trit_check.sv | 18 +
 rtl/curl_hash_driver.sv | 138 +++++++++++++
 tb/tb_curl_hash_driver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/curl_pkg.sv
// Shared definitions for the Curl transform driver: block geometry, trit codes and FSM states.
package curl_pkg;

    localparam int unsigned HASH_LENGTH = 243;
    localparam int unsigned BLK_W       = 2 * HASH_LENGTH;

    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_NEG  = 2'b11;
    localparam logic [1:0] TRIT_INV  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LO,
        LOAD_HI,
        WAIT,
        ERR,
        RESP
    } curl_drv_state_t;

    // True for the three balanced-ternary codes the transform unit understands.
    function automatic logic trit_legal(input logic [1:0] t);
        return (t == TRIT_POS) || (t == TRIT_ZERO) || (t == TRIT_NEG);
    endfunction

endpackage

// File: rtl/curl_trit_check.sv
// Combinational scan of a full block: flags any trit carrying the illegal code.
module curl_trit_check
    import curl_pkg::*;
(
    input  logic [BLK_W-1:0] blk,
    output logic             illegal_c
);

    always_comb begin
        illegal_c = 1'b0;
        for (int unsigned k = 0; k < HASH_LENGTH; k++) begin
            if (!trit_legal(blk[2*k +: 2])) begin
                illegal_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/curl_hash_driver.sv
// Initiator for the multicycle Curl transform: loads a block in two halves, waits, returns the result.
// Optional WAIT watchdog enabled by defining CURL_DRV_TIMEOUT_EN.
module curl_hash_driver
    import curl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
`ifdef CURL_DRV_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_blk_valid,
    output logic                   o_blk_ready,
    input  logic [BLK_W-1:0]       i_blk,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [BLK_W-1:0]       o_res,
    output logic                   o_res_err,
    output logic                   o_busy,
    output logic [CNT_W-1:0]       o_blk_cnt,
    output logic                   o_curl_first_part,
    output logic                   o_curl_new_hash,
    output logic [HASH_LENGTH-1:0] o_curl_hash,
    input  logic [BLK_W-1:0]       i_curl_hash,
    input  logic                   i_curl_finish
);

    curl_drv_state_t          state;
    logic [HASH_LENGTH-1:0]   blk_hi;
    logic                     blk_illegal_c;

`ifdef CURL_DRV_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] wait_cnt;
`endif

    curl_trit_check u_trit_check (
        .blk       (i_blk),
        .illegal_c (blk_illegal_c)
    );

    // The low half goes straight from the input port into the first load; only the high half is kept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= IDLE;
            blk_hi            <= '0;
            o_blk_ready       <= 1'b1;
            o_res_valid       <= 1'b0;
            o_res             <= '0;
            o_res_err         <= 1'b0;
            o_busy            <= 1'b0;
            o_blk_cnt         <= '0;
            o_curl_first_part <= 1'b0;
            o_curl_new_hash   <= 1'b0;
            o_curl_hash       <= '0;
`ifdef CURL_DRV_TIMEOUT_EN
            wait_cnt          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_blk_valid && o_blk_ready) begin
                        o_blk_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        blk_hi      <= i_blk[BLK_W-1:HASH_LENGTH];
                        if (blk_illegal_c) begin
                            state <= ERR;
                        end else begin
                            state             <= LOAD_LO;
                            o_curl_first_part <= 1'b1;
                            o_curl_hash       <= i_blk[HASH_LENGTH-1:0];
                        end
                    end
                end
                LOAD_LO: begin
                    o_curl_first_part <= 1'b0;
                    o_curl_new_hash   <= 1'b1;
                    o_curl_hash       <= blk_hi;
                    state             <= LOAD_HI;
                end
                LOAD_HI: begin
                    o_curl_new_hash <= 1'b0;
                    o_curl_hash     <= '0;
                    state           <= WAIT;
`ifdef CURL_DRV_TIMEOUT_EN
                    wait_cnt        <= '0;
`endif
                end
                WAIT: begin
                    // A finish arriving together with the timeout still delivers the real result.
                    if (i_curl_finish) begin
                        o_res       <= i_curl_hash;
                        o_res_err   <= 1'b0;
                        o_res_valid <= 1'b1;
                        state       <= RESP;
                    end
`ifdef CURL_DRV_TIMEOUT_EN
                    else if (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        o_res       <= '0;
                        o_res_err   <= 1'b1;
                        o_res_valid <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + TMO_W'(1);
                    end
`endif
                end
                ERR: begin
                    o_res       <= '0;
                    o_res_err   <= 1'b1;
                    o_res_valid <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (i_res_ready) begin
                        o_res_valid <= 1'b0;
                        o_blk_cnt   <= o_blk_cnt + CNT_W'(1);
                        o_busy      <= 1'b0;
                        o_blk_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    strobes_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_curl_first_part && o_curl_new_hash));

    hash_idle_zero: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (!o_curl_first_part && !o_curl_new_hash) |-> (o_curl_hash == '0));

endmodule

// File: tb/tb_curl_hash_driver.sv
// Self-checking bench for curl_hash_driver; the bench plays the transform unit and the block source/sink.
`timescale 1ns/1ps
module tb_curl_hash_driver;
    import curl_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   blk_valid = 1'b0;
    logic                   blk_ready;
    logic [BLK_W-1:0]       blk = '0;
    logic                   res_valid;
    logic                   res_ready = 1'b0;
    logic [BLK_W-1:0]       res;
    logic                   res_err;
    logic                   busy;
    logic [CNT_W-1:0]       blk_cnt;
    logic                   first_part;
    logic                   new_hash;
    logic [HASH_LENGTH-1:0] curl_hash_o;
    logic [BLK_W-1:0]       curl_hash_i = '0;
    logic                   curl_finish = 1'b0;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    curl_hash_driver #(
        .CNT_W(CNT_W)
`ifdef CURL_DRV_TIMEOUT_EN
        , .TIMEOUT_CYCLES(10)
`endif
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_blk_valid       (blk_valid),
        .o_blk_ready       (blk_ready),
        .i_blk             (blk),
        .o_res_valid       (res_valid),
        .i_res_ready       (res_ready),
        .o_res             (res),
        .o_res_err         (res_err),
        .o_busy            (busy),
        .o_blk_cnt         (blk_cnt),
        .o_curl_first_part (first_part),
        .o_curl_new_hash   (new_hash),
        .o_curl_hash       (curl_hash_o),
        .i_curl_hash       (curl_hash_i),
        .i_curl_finish     (curl_finish)
    );

    task automatic check(input string tag, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BLK_W-1:0] rand_bits();
        logic [BLK_W-1:0] v;
        v = '0;
        for (int k = 0; k < int'(BLK_W); k++) v[k] = 1'($urandom);
        return v;
    endfunction

    function automatic logic [BLK_W-1:0] rand_legal_blk();
        logic [BLK_W-1:0] v;
        logic [1:0] codes [3];
        codes = '{2'b00, 2'b01, 2'b11};
        v = '0;
        for (int k = 0; k < int'(HASH_LENGTH); k++) v[2*k +: 2] = codes[$urandom_range(0, 2)];
        return v;
    endfunction

    // Reference rule: a block is rejected when any trit holds code 2'b10.
    function automatic logic blk_has_inv(input logic [BLK_W-1:0] b);
        logic [1:0] t;
        for (int k = 0; k < int'(HASH_LENGTH); k++) begin
            t = b[2*k +: 2];
            if (t == 2'b10) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_blk_ready"}, BLK_W'(blk_ready), BLK_W'(1));
        check({tag, "_res_valid"}, BLK_W'(res_valid), BLK_W'(0));
        check({tag, "_res"}, res, BLK_W'(0));
        check({tag, "_res_err"}, BLK_W'(res_err), BLK_W'(0));
        check({tag, "_busy"}, BLK_W'(busy), BLK_W'(0));
        check({tag, "_blk_cnt"}, BLK_W'(blk_cnt), BLK_W'(0));
        check({tag, "_strobes"}, BLK_W'({first_part, new_hash}), BLK_W'(0));
        check({tag, "_curl_hash"}, BLK_W'(curl_hash_o), BLK_W'(0));
    endtask

    // One full transaction: fd extra WAIT cycles before finish, rd cycles of result backpressure.
    task automatic do_txn(input logic [BLK_W-1:0] b, input int fd, input int rd);
        logic             ill;
        logic [BLK_W-1:0] exp_res;
        int               n;
        ill = blk_has_inv(b);
        n = 0;
        while (!blk_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_before_accept", BLK_W'(blk_ready), BLK_W'(1));
        blk       = b;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        blk       = rand_bits();
        check("busy_after_accept", BLK_W'(busy), BLK_W'(1));
        check("ready_low_after_accept", BLK_W'(blk_ready), BLK_W'(0));
        if (ill) begin
            check("err_no_strobes", BLK_W'({first_part, new_hash}), BLK_W'(0));
            check("err_no_early_valid", BLK_W'(res_valid), BLK_W'(0));
            tick();
            exp_res = '0;
            check("err_no_strobes_2", BLK_W'({first_part, new_hash}), BLK_W'(0));
        end else begin
            check("first_part", BLK_W'({first_part, new_hash}), BLK_W'(2'b10));
            check("hash_lo", BLK_W'(curl_hash_o), BLK_W'(b[HASH_LENGTH-1:0]));
            tick();
            check("new_hash", BLK_W'({first_part, new_hash}), BLK_W'(2'b01));
            check("hash_hi", BLK_W'(curl_hash_o), BLK_W'(b[BLK_W-1:HASH_LENGTH]));
            curl_finish = 1'b0;
            curl_hash_i = rand_bits();
            tick();
            check("wait_strobes_low", BLK_W'({first_part, new_hash}), BLK_W'(0));
            check("wait_hash_zero", BLK_W'(curl_hash_o), BLK_W'(0));
            for (int i = 0; i < fd; i++) begin
                check("wait_no_valid", BLK_W'(res_valid), BLK_W'(0));
                tick();
            end
            check("wait_no_valid_last", BLK_W'(res_valid), BLK_W'(0));
            exp_res     = rand_bits();
            curl_hash_i = exp_res;
            curl_finish = 1'b1;
            tick();
            curl_hash_i = rand_bits();
        end
        check("res_valid", BLK_W'(res_valid), BLK_W'(1));
        check("res", res, exp_res);
        check("res_err", BLK_W'(res_err), BLK_W'(ill));
        for (int i = 0; i < rd; i++) begin
            tick();
            check("bp_valid", BLK_W'(res_valid), BLK_W'(1));
            check("bp_res_stable", res, exp_res);
            check("bp_ready_low", BLK_W'(blk_ready), BLK_W'(0));
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_cnt   = (exp_cnt + 1) % (1 << CNT_W);
        check("hs_valid_low", BLK_W'(res_valid), BLK_W'(0));
        check("hs_blk_cnt", BLK_W'(blk_cnt), BLK_W'(exp_cnt));
        check("hs_ready_back", BLK_W'(blk_ready), BLK_W'(1));
        check("hs_busy_low", BLK_W'(busy), BLK_W'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [BLK_W-1:0] b;
        int               n;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_txn('0, 3, 0);

        b = rand_legal_blk();
        b[201:200] = 2'b10;
        do_txn(b, 0, 0);

        do_txn(rand_legal_blk(), 5, 50);

        // Stray finish in IDLE, and finish still high from the last transaction during the next load.
        curl_finish = 1'b1;
        tick();
        check("stray_idle_ready", BLK_W'(blk_ready), BLK_W'(1));
        check("stray_idle_valid", BLK_W'(res_valid), BLK_W'(0));
        check("stray_idle_busy", BLK_W'(busy), BLK_W'(0));
        curl_finish = 1'b0;
        tick();
        curl_finish = 1'b1;
        do_txn(rand_legal_blk(), 2, 1);

        for (int t = 0; t < 10; t++) begin
            b = rand_legal_blk();
            if ($urandom_range(0, 2) == 0) b[2*$urandom_range(0, HASH_LENGTH-1) +: 2] = 2'b10;
            do_txn(b, int'($urandom_range(0, 8)), int'($urandom_range(0, 3)));
        end

        // Reset asserted while waiting for finish.
        curl_finish = 1'b0;
        blk         = rand_legal_blk();
        blk_valid   = 1'b1;
        tick();
        blk_valid = 1'b0;
        repeat (3) tick();
        check("pre_reset_busy", BLK_W'(busy), BLK_W'(1));
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_txn(rand_legal_blk(), 4, 2);

`ifdef CURL_DRV_TIMEOUT_EN
        curl_finish = 1'b0;
        blk         = rand_legal_blk();
        blk_valid   = 1'b1;
        tick();
        blk_valid = 1'b0;
        tick();
        check("tmo_new_hash", BLK_W'(new_hash), BLK_W'(1));
        n = 0;
        do begin
            tick();
            n++;
        end while (!res_valid && n < 100);
        check("tmo_latency", BLK_W'(n), BLK_W'(11));
        check("tmo_err", BLK_W'(res_err), BLK_W'(1));
        check("tmo_res", res, BLK_W'(0));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_cnt   = (exp_cnt + 1) % (1 << CNT_W);
        check("tmo_blk_cnt", BLK_W'(blk_cnt), BLK_W'(exp_cnt));
`else
        n = 0;
`endif
        check("final_blk_cnt", BLK_W'(blk_cnt), BLK_W'(exp_cnt + n - n));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
